// File: rtl/clock_pkg.sv
// Shared types and default timing for the game clock-tree sequencer.
package clock_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        OSC_WAIT    = 3'd1,
        PLL_RST     = 3'd2,
        LOCK_WAIT   = 3'd3,
        LOCK_STABLE = 3'd4,
        RUN         = 3'd5,
        FAULT       = 3'd6
    } state_t;

    localparam int DEF_OSC_START_CYCLES    = 4;
    localparam int DEF_PLL_RESET_CYCLES    = 2;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 64;
    localparam int DEF_LOCK_STABLE_CYCLES  = 16;
    localparam int DEF_MAX_RETRIES         = 3;

    // Largest of the four timing constants; sizes the shared cycle counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into clk.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample on the same
            // edge; blocking here would collapse the chain into a single stage.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clock_sequencer.sv
// Power-up / recovery sequencer: HFOSC enable, PLL reset, lock qualification,
// retry on lock timeout and game reset release. Outputs are decoded from state.
module clock_sequencer
    import clock_pkg::*;
#(
    parameter int OSC_START_CYCLES    = DEF_OSC_START_CYCLES,
    parameter int PLL_RESET_CYCLES    = DEF_PLL_RESET_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           pll_lock,
    output logic                           hfosc_enable,
    output logic                           pll_resetb,
    output logic                           game_reset_n,
    output logic                           clocks_ready,
    output logic                           fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);

    localparam int CNT_W = $clog2(max4(OSC_START_CYCLES, PLL_RESET_CYCLES,
                                       LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)) + 1;
    localparam int RC_W  = $clog2(MAX_RETRIES+1);

    localparam logic [CNT_W-1:0] OSC_LAST     = CNT_W'(OSC_START_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RC_W-1:0]  RETRY_LIMIT  = RC_W'(MAX_RETRIES);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt_q, cnt_next;
    logic [RC_W-1:0]   retry_q, retry_next;
    logic              lock_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // State, shared cycle counter and retry counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state   <= state_next;
            cnt_q   <= cnt_next;
            retry_q <= retry_next;
        end
    end

    // Next-state, counter update and Moore output decode.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave one unassigned and infer a latch.
        state_next   = state;
        retry_next   = retry_q;
        cnt_next     = cnt_q;
        hfosc_enable = 1'b0;
        pll_resetb   = 1'b0;
        game_reset_n = 1'b0;
        clocks_ready = 1'b0;
        fault        = 1'b0;

        // Dropping start aborts from anywhere and beats every other event.
        if (!start) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:        state_next = OSC_WAIT;
                OSC_WAIT:    if (cnt_q == OSC_LAST) state_next = PLL_RST;
                PLL_RST:     if (cnt_q == RST_LAST) state_next = LOCK_WAIT;
                LOCK_WAIT: begin
                    if (lock_s) begin
                        state_next = LOCK_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q < RETRY_LIMIT) begin
                            retry_next = retry_q + 1'b1;
                            state_next = PLL_RST;
                        end else begin
                            state_next = FAULT;
                        end
                    end
                end
                // A lock drop wins over a completing stable count.
                LOCK_STABLE: begin
                    if (!lock_s)                    state_next = LOCK_WAIT;
                    else if (cnt_q == STABLE_LAST)  state_next = RUN;
                end
                RUN:         if (!lock_s) state_next = PLL_RST;
                FAULT:       state_next = FAULT;
                default:     state_next = IDLE;
            endcase
        end

        // Retries belong to one sequence: cleared in IDLE and once RUN is reached.
        if (state == IDLE || state_next == IDLE || state_next == RUN)
            retry_next = '0;

        // Shared counter restarts on every state change and saturates otherwise.
        if (state_next != state)
            cnt_next = '0;
        else if (cnt_q != '1)
            cnt_next = cnt_q + 1'b1;

        case (state)
            OSC_WAIT, PLL_RST: begin
                hfosc_enable = 1'b1;
            end
            LOCK_WAIT, LOCK_STABLE: begin
                hfosc_enable = 1'b1;
                pll_resetb   = 1'b1;
            end
            RUN: begin
                hfosc_enable = 1'b1;
                pll_resetb   = 1'b1;
                game_reset_n = 1'b1;
                clocks_ready = 1'b1;
            end
            FAULT: begin
                hfosc_enable = 1'b1;
                pll_resetb   = 1'b1;
                fault        = 1'b1;
            end
            default: ;
        endcase
    end

    assign retry_count = retry_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// Directed self-checking bench for clock_sequencer with default parameters.
// Edge numbering: start is raised just after an edge; the next rising edge is edge 1.
module tb_clock_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       pll_lock;
    logic       hfosc_enable;
    logic       pll_resetb;
    logic       game_reset_n;
    logic       clocks_ready;
    logic       fault;
    logic [1:0] retry_count;

    int checks = 0;
    int errors = 0;

    logic [6:0] outs;
    logic [6:0] exp_v;
    assign outs = {hfosc_enable, pll_resetb, game_reset_n, clocks_ready, fault, retry_count};

    clock_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pll_lock     (pll_lock),
        .hfosc_enable (hfosc_enable),
        .pll_resetb   (pll_resetb),
        .game_reset_n (game_reset_n),
        .clocks_ready (clocks_ready),
        .fault        (fault),
        .retry_count  (retry_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output vector: {hfosc, resetb, game_reset_n, clocks_ready, fault, retry}.
    function automatic logic [6:0] mk(input bit h, input bit r, input bit g,
                                      input bit f, input logic [1:0] rc);
        return {h, r, g, g, f, rc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Park in IDLE with the given pin level long enough for lock_s to settle.
    task automatic go_idle(input bit lock_level);
        start    = 1'b0;
        pll_lock = lock_level;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pll_lock = 1'b0;
        #3;
        checks++;
        if (outs !== 7'd0) begin
            errors++;
            $display("FAIL reset_async: got %b expected %b", outs, 7'd0);
        end
        #10;
        rst_n = 1'b1;
        tick();
        checks++;
        if (outs !== 7'd0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected %b", outs, 7'd0);
        end
    endtask

    task automatic test_happy_path();
        go_idle(1'b1);
        start = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            tick();
            exp_v = mk(1'b1, e >= 7, e >= 24, 1'b0, 2'd0);
            checks++;
            if (outs !== exp_v) begin
                errors++;
                $display("FAIL happy edge %0d: got %b expected %b", e, outs, exp_v);
            end
        end
    endtask

    task automatic test_late_lock();
        go_idle(1'b0);
        start = 1'b1;
        for (int e = 1; e <= 56; e++) begin
            tick();
            if (e == 37) pll_lock = 1'b1;   // 30 cycles after LOCK_WAIT entry at edge 7
            exp_v = mk(1'b1, e >= 7, e >= 56, 1'b0, 2'd0);
            checks++;
            if (outs !== exp_v) begin
                errors++;
                $display("FAIL late_lock edge %0d: got %b expected %b", e, outs, exp_v);
            end
        end
    endtask

    task automatic test_no_lock();
        logic       rb;
        logic [1:0] rc;
        go_idle(1'b0);
        start = 1'b1;
        for (int e = 1; e <= 279; e++) begin
            tick();
            rb = !((e <= 6) || (e >= 71 && e <= 72) || (e >= 137 && e <= 138) ||
                   (e >= 203 && e <= 204));
            rc = (e < 71) ? 2'd0 : (e < 137) ? 2'd1 : (e < 203) ? 2'd2 : 2'd3;
            exp_v = mk(1'b1, rb, 1'b0, e >= 269, rc);
            checks++;
            if (outs !== exp_v) begin
                errors++;
                $display("FAIL no_lock edge %0d: got %b expected %b", e, outs, exp_v);
            end
        end
        start = 1'b0;
        tick();
        checks++;
        if (outs !== 7'd0) begin
            errors++;
            $display("FAIL fault_exit: got %b expected %b", outs, 7'd0);
        end
    endtask

    // Ends in RUN at edge 39 with the pin high.
    task automatic test_glitchy_lock();
        go_idle(1'b0);
        start = 1'b1;
        for (int e = 1; e <= 39; e++) begin
            tick();
            if (e == 9)  pll_lock = 1'b1;
            if (e == 19) pll_lock = 1'b0;
            if (e == 20) pll_lock = 1'b1;
            exp_v = mk(1'b1, e >= 7, e >= 39, 1'b0, 2'd0);
            checks++;
            if (outs !== exp_v) begin
                errors++;
                $display("FAIL glitch edge %0d: got %b expected %b", e, outs, exp_v);
            end
        end
    endtask

    // Starts in RUN; loses lock, burns one retry, relocks and returns to RUN.
    task automatic test_lock_loss();
        logic rb;
        pll_lock = 1'b0;
        for (int j = 1; j <= 90; j++) begin
            tick();
            if (j == 71) pll_lock = 1'b1;
            rb = !((j >= 3 && j <= 4) || (j >= 69 && j <= 70));
            exp_v = mk(1'b1, rb, (j < 3) || (j >= 90), 1'b0,
                       (j >= 69 && j < 90) ? 2'd1 : 2'd0);
            checks++;
            if (outs !== exp_v) begin
                errors++;
                $display("FAIL lock_loss edge %0d: got %b expected %b", j, outs, exp_v);
            end
        end
    endtask

    task automatic test_abort();
        go_idle(1'b1);
        start = 1'b1;
        repeat (12) tick();
        exp_v = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL abort_stable: got %b expected %b", outs, exp_v);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 7'd0) begin
            errors++;
            $display("FAIL abort_rst_async: got %b expected %b", outs, 7'd0);
        end
        start = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (outs !== 7'd0) begin
            errors++;
            $display("FAIL abort_rst_idle: got %b expected %b", outs, 7'd0);
        end
        start = 1'b1;
        tick();
        tick();
        exp_v = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        checks++;
        if (outs !== exp_v) begin
            errors++;
            $display("FAIL abort_osc_wait: got %b expected %b", outs, exp_v);
        end
        start = 1'b0;
        tick();
        checks++;
        if (outs !== 7'd0) begin
            errors++;
            $display("FAIL abort_start: got %b expected %b", outs, 7'd0);
        end
    endtask

    initial begin
        test_reset();
        test_happy_path();
        test_late_lock();
        test_no_lock();
        test_glitchy_lock();
        test_lock_loss();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
